// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-panel sequencer.
// Contents: digit/time widths, default saturation value and the state encoding
// that also appears on the LED/debug state_code output.
package stopwatch_pkg;

  localparam int DIGIT_WIDTH = 4;
  localparam int TIME_WIDTH  = 4 * DIGIT_WIDTH;

  localparam logic [15:0] MAX_TIME_DEFAULT = 16'h5959;

  // Encoding is visible externally through state_code, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for one debounced push-button level.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   level      : debounced button level
//   press      : high for the single cycle in which level is first seen high
// press is combinational from the current level and the registered history so
// the consumer can act on the very edge that first samples the button high.
module button_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);

  logic r_prev;

  // Button history: remembers the level sampled at the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= level;
    end
  end

  assign press = level & ~r_prev;

endmodule

// File: rtl/stopwatch_control.sv
// Front-panel sequencer for the MM:SS stopwatch.
// Runs the IDLE/RUN/PAUSE/LAP/DONE state machine from debounced start, lap and
// clear buttons, gates the 1 Hz tick into the BCD counter chain, issues a
// one-cycle synchronous clear to the counters and selects live or lap-frozen
// time for the display.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   tick_in        : one-cycle 1 Hz pulse
//   btn_start/lap/clear : debounced button levels
//   time_in        : packed BCD count from the counter chain
//   count_en       : gated tick to the first counter stage
//   count_clear    : one-cycle clear to all digit counters
//   display_value  : value to the display driver
//   display_frozen : high while a lap value is shown
//   running        : high in RUN or LAP
//   state_code     : current state for LEDs/debug
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int              TIME_WIDTH  = 16,
  parameter logic [15:0]     MAX_TIME    = 16'h5959,
  parameter bit              STOP_AT_MAX = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_in,
  input  logic                  btn_start,
  input  logic                  btn_lap,
  input  logic                  btn_clear,
  input  logic [TIME_WIDTH-1:0] time_in,
  output logic                  count_en,
  output logic                  count_clear,
  output logic [TIME_WIDTH-1:0] display_value,
  output logic                  display_frozen,
  output logic                  running,
  output logic [2:0]            state_code
);

  state_t                r_state;
  logic                  r_count_clear;
  logic [TIME_WIDTH-1:0] r_lap;

  logic w_start_raw;
  logic w_lap_raw;
  logic w_clear_p;
  logic w_start_p;
  logic w_lap_p;
  logic w_active;
  logic w_sat;
  logic w_sat_tick;

  button_edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .level(btn_start), .press(w_start_raw));
  button_edge_detect u_lap_edge   (.clk(clk), .rst_n(rst_n), .level(btn_lap),   .press(w_lap_raw));
  button_edge_detect u_clear_edge (.clk(clk), .rst_n(rst_n), .level(btn_clear), .press(w_clear_p));

  // Same-cycle presses resolve clear > start > lap; losers are dropped even
  // when the winner is ignored in the current state.
  assign w_start_p = w_start_raw & ~w_clear_p;
  assign w_lap_p   = w_lap_raw & ~w_clear_p & ~w_start_raw;

  assign w_active   = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_sat      = STOP_AT_MAX && (time_in == MAX_TIME[TIME_WIDTH-1:0]);
  assign w_sat_tick = w_sat & tick_in;

  // Gating follows the current state, so a tick coinciding with a stop press
  // still advances the count.
  assign count_en = tick_in & w_active & ~w_sat;

  // Sequencer state, clear pulse and lap capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_count_clear <= 1'b0;
      r_lap         <= '0;
    end else begin
      r_count_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_clear_p) begin
            r_count_clear <= 1'b1;
            r_lap         <= '0;
          end else if (w_start_p) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_sat_tick) begin
            r_state <= ST_DONE;
          end else if (w_start_p) begin
            r_state <= ST_PAUSE;
          end else if (w_lap_p) begin
            r_state <= ST_LAP;
            r_lap   <= time_in;
          end
        end
        ST_LAP: begin
          if (w_sat_tick) begin
            r_state <= ST_DONE;
          end else if (w_start_p) begin
            r_state <= ST_PAUSE;
          end else if (w_lap_p) begin
            r_state <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (w_clear_p) begin
            r_state       <= ST_IDLE;
            r_count_clear <= 1'b1;
            r_lap         <= '0;
          end else if (w_start_p) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (w_clear_p) begin
            r_state       <= ST_IDLE;
            r_count_clear <= 1'b1;
            r_lap         <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All remaining outputs decode directly from registered state.
  assign count_clear    = r_count_clear;
  assign display_frozen = (r_state == ST_LAP);
  assign running        = w_active;
  assign state_code     = r_state;
  assign display_value  = display_frozen ? r_lap : time_in;

endmodule
